// File: rtl/ssd_value_encoder.sv
// ---------------------------------------------------------------------------
// ssd_value_encoder
//
// Feeds the 4-digit seven-segment scan driver. On an accepted load pulse the
// binary value is converted to four BCD digits by a sequential double-dabble
// engine (one bit per clock). The digits are then mapped to active-low segment
// patterns and registered on SSD3..SSD0, with SSD3 being the leftmost digit.
// The patterns stay stable between conversions, so the scan driver may sample
// them at any time.
//
// Optional feature macro: SSD_ENC_BLINK_EN
//   defined   -> adds the blink_en port, the BLINK_DIV parameter and a
//                free-running blink phase; when blink_en=1 and the phase is
//                high, every digit shows dark (7'h7F).
//   undefined -> no blink hardware; the display is always steady.
//
// Parameters
//   VALUE_W    width of the binary input (values above 9999 show "----")
//   BLINK_DIV  clk cycles per blink half-period (blink build only)
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous reset, active low
//   load       in   1        start a conversion; honoured only when busy=0
//   value      in   VALUE_W  unsigned binary value, sampled on accepted load
//   blank_lz   in   1        1 = blank leading zeros, sampled on accepted load
//   blink_en   in   1        blink enable (blink build only)
//   busy       out  1        conversion in progress
//   done       out  1        one-cycle pulse, new patterns valid
//   SSD3..SSD0 out  7 each   segments {a,b,c,d,e,f,g}, 0 = lit
// ---------------------------------------------------------------------------
module ssd_value_encoder #(
  parameter int VALUE_W = 14
`ifdef SSD_ENC_BLINK_EN
  ,
  parameter int BLINK_DIV = 25000000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  input  logic               blank_lz,
`ifdef SSD_ENC_BLINK_EN
  input  logic               blink_en,
`endif
  output logic               busy,
  output logic               done,
  output logic [6:0]         SSD3,
  output logic [6:0]         SSD2,
  output logic [6:0]         SSD1,
  output logic [6:0]         SSD0
);

  localparam int              CNT_W     = $clog2(VALUE_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VALUE_W - 1);
  localparam logic [6:0]      SEG_BLANK = 7'h7F;
  localparam logic [6:0]      SEG_DASH  = 7'h7E;
  localparam logic [31:0]     MAX_DEC   = 32'd9999;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_ENCODE = 2'd2
  } state_t;

  // Active-low segment pattern for one decimal digit; non-decimal codes go dark.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h01;
      4'd1:    seg = 7'h4F;
      4'd2:    seg = 7'h12;
      4'd3:    seg = 7'h06;
      4'd4:    seg = 7'h4C;
      4'd5:    seg = 7'h24;
      4'd6:    seg = 7'h20;
      4'd7:    seg = 7'h0F;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h04;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end else begin
        res[4*k +: 4] = bcd[4*k +: 4];
      end
    end
    return res;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_shift;
  logic               w_encode;

  logic [VALUE_W-1:0] r_bin;
  logic [15:0]        r_bcd;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_lz;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;
  logic [6:0]         r_ssd3;
  logic [6:0]         r_ssd2;
  logic [6:0]         r_ssd1;
  logic [6:0]         r_ssd0;

  logic               w_ovf;
  logic [15:0]        w_bcd_adj;
  logic [VALUE_W+15:0] w_shifted;
  logic [3:0]         w_dig3;
  logic [3:0]         w_dig2;
  logic [3:0]         w_dig1;
  logic [3:0]         w_dig0;
  logic               w_blank3;
  logic               w_blank2;
  logic               w_blank1;
  logic [6:0]         w_pat3;
  logic [6:0]         w_pat2;
  logic [6:0]         w_pat1;
  logic [6:0]         w_pat0;

  // Overflow flag for the incoming value, zero-extended for a width-safe compare.
  assign w_ovf = (32'(value) > MAX_DEC);

  // One double-dabble step: adjust the BCD nibbles, then shift {BCD,bin} left by one.
  assign w_bcd_adj = bcd_adjust(r_bcd);
  assign w_shifted = {w_bcd_adj, r_bin} << 1;

  assign w_dig3 = r_bcd[15:12];
  assign w_dig2 = r_bcd[11:8];
  assign w_dig1 = r_bcd[7:4];
  assign w_dig0 = r_bcd[3:0];

  // A digit is a leading zero only if it and every digit to its left are zero.
  assign w_blank3 = r_lz && (w_dig3 == 4'd0);
  assign w_blank2 = w_blank3 && (w_dig2 == 4'd0);
  assign w_blank1 = w_blank2 && (w_dig1 == 4'd0);

  // Pattern selection: overflow dashes win over blanking; SSD0 is never blanked.
  always_comb begin
    w_pat3 = seg_encode(w_dig3);
    w_pat2 = seg_encode(w_dig2);
    w_pat1 = seg_encode(w_dig1);
    w_pat0 = seg_encode(w_dig0);
    if (r_ovf) begin
      w_pat3 = SEG_DASH;
      w_pat2 = SEG_DASH;
      w_pat1 = SEG_DASH;
      w_pat0 = SEG_DASH;
    end else begin
      if (w_blank3) begin
        w_pat3 = SEG_BLANK;
      end else begin
        w_pat3 = seg_encode(w_dig3);
      end
      if (w_blank2) begin
        w_pat2 = SEG_BLANK;
      end else begin
        w_pat2 = seg_encode(w_dig2);
      end
      if (w_blank1) begin
        w_pat1 = SEG_BLANK;
      end else begin
        w_pat1 = seg_encode(w_dig1);
      end
    end
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_encode    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_bit_cnt == LAST_BIT) begin
          w_state_nxt = S_ENCODE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_ENCODE: begin
        w_encode    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Conversion datapath: capture on accept, one shift per SHIFT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin     <= '0;
      r_bcd     <= 16'h0000;
      r_bit_cnt <= '0;
      r_lz      <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_bin     <= value;
      r_bcd     <= 16'h0000;
      r_bit_cnt <= '0;
      r_lz      <= blank_lz;
      r_ovf     <= w_ovf;
    end else if (w_shift) begin
      r_bin     <= w_shifted[VALUE_W-1:0];
      r_bcd     <= w_shifted[VALUE_W+15:VALUE_W];
      r_bit_cnt <= r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_bin     <= r_bin;
      r_bcd     <= r_bcd;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Status flags: busy follows the state the FSM is heading into; done marks the ENCODE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_encode;
    end
  end

  // Stored segment patterns, updated only on the ENCODE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ssd3 <= SEG_BLANK;
      r_ssd2 <= SEG_BLANK;
      r_ssd1 <= SEG_BLANK;
      r_ssd0 <= SEG_BLANK;
    end else if (w_encode) begin
      r_ssd3 <= w_pat3;
      r_ssd2 <= w_pat2;
      r_ssd1 <= w_pat1;
      r_ssd0 <= w_pat0;
    end else begin
      r_ssd3 <= r_ssd3;
      r_ssd2 <= r_ssd2;
      r_ssd1 <= r_ssd1;
      r_ssd0 <= r_ssd0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;

`ifdef SSD_ENC_BLINK_EN
  localparam int              DIV_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0] r_blink_cnt;
  logic             r_phase;
  logic             w_dark;

  // Free-running half-period counter; the phase toggles each time it wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == DIV_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
      r_phase     <= r_phase;
    end
  end

  // Blink only gates the visible outputs; the stored patterns are left intact.
  assign w_dark = blink_en && r_phase;
  assign SSD3   = w_dark ? SEG_BLANK : r_ssd3;
  assign SSD2   = w_dark ? SEG_BLANK : r_ssd2;
  assign SSD1   = w_dark ? SEG_BLANK : r_ssd1;
  assign SSD0   = w_dark ? SEG_BLANK : r_ssd0;
`else
  assign SSD3 = r_ssd3;
  assign SSD2 = r_ssd2;
  assign SSD1 = r_ssd1;
  assign SSD0 = r_ssd0;
`endif

endmodule

// File: tb/tb_ssd_value_encoder.sv
module tb_ssd_value_encoder;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [13:0] value    = 14'd0;
  logic        busy;
  logic        done;
  logic [6:0]  SSD3;
  logic [6:0]  SSD2;
  logic [6:0]  SSD1;
  logic [6:0]  SSD0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ssd_value_encoder #(.VALUE_W(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .SSD3     (SSD3),
    .SSD2     (SSD2),
    .SSD1     (SSD1),
    .SSD0     (SSD0)
  );

  // Expected display for a value, straight from decimal arithmetic.
  function automatic logic [27:0] m_expect(input int v, input bit lz);
    logic [6:0] tbl [10];
    logic [6:0] s3, s2, s1, s0;
    int d3, d2, d1, d0;
    tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    if (v > 9999) return {4{7'h7E}};
    d3 = v / 1000;
    d2 = (v / 100) % 10;
    d1 = (v / 10) % 10;
    d0 = v % 10;
    s3 = tbl[d3]; s2 = tbl[d2]; s1 = tbl[d1]; s0 = tbl[d0];
    if (lz) begin
      if (d3 == 0) s3 = 7'h7F;
      if (d3 == 0 && d2 == 0) s2 = 7'h7F;
      if (d3 == 0 && d2 == 0 && d1 == 0) s1 = 7'h7F;
    end
    return {s3, s2, s1, s0};
  endfunction

  // Timing model: a conversion accepted at an edge completes 15 edges later.
  logic [27:0] m_ssd  = {4{7'h7F}};
  logic [27:0] m_pend = {4{7'h7F}};
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_rem  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ssd  <= {4{7'h7F}};
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_rem  <= 0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_ssd  <= m_pend;
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (load) begin
        m_pend <= m_expect(int'(value), blank_lz);
        m_rem  <= 15;
        m_busy <= 1'b1;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, SSD3, SSD2, SSD1, SSD0} !== {m_busy, m_done, m_ssd}) begin
        n_miss++;
        $display("FAIL cycle_check t=%0t: got busy=%b done=%b ssd=%h, want busy=%b done=%b ssd=%h",
                 $time, busy, done, {SSD3, SSD2, SSD1, SSD0}, m_busy, m_done, m_ssd);
      end
    end
  end

  task automatic chk(input string nm, input logic [29:0] act, input logic [29:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Caller is at a negedge; returns one negedge later with load dropped.
  task automatic pulse_load(input int v, input bit lz);
    load     = 1'b1;
    value    = v[13:0];
    blank_lz = lz;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles seen on the way.
  task automatic wait_done(output int bcnt, output bit got);
    bcnt = 0;
    got  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy) bcnt++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic run(input string nm, input int v, input bit lz, input logic [27:0] exp,
                     output int bcnt);
    bit got;
    pulse_load(v, lz);
    wait_done(bcnt, got);
    chk({nm, "_done"}, 30'(got), 30'd1);
    chk(nm, 30'({SSD3, SSD2, SSD1, SSD0}), 30'(exp));
  endtask

  initial begin
    int bcnt;
    int nd;
    bit got;

    // Reset state
    @(negedge clk);
    chk("reset_state", {busy, done, SSD3, SSD2, SSD1, SSD0}, {2'b00, {4{7'h7F}}});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Model pinned against hand-computed patterns
    chk("model_1234", 30'(m_expect(1234, 1'b0)), 30'({7'h4F, 7'h12, 7'h06, 7'h4C}));
    chk("model_0_lz", 30'(m_expect(0, 1'b1)), 30'({7'h7F, 7'h7F, 7'h7F, 7'h01}));

    // Basic conversion, latency and busy length
    run("v1234", 1234, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, bcnt);
    chk("v1234_busy_len", 30'(bcnt), 30'd15);

    // Leading-zero handling (each load lands on the previous done cycle)
    run("v7_lz", 7, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h0F}, bcnt);
    run("v7_nolz", 7, 1'b0, {7'h01, 7'h01, 7'h01, 7'h0F}, bcnt);
    run("v0_lz", 0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}, bcnt);
    run("v105_lz", 105, 1'b1, {7'h7F, 7'h4F, 7'h01, 7'h24}, bcnt);

    // Overflow and upper decimal bound
    run("v10000", 10000, 1'b0, {4{7'h7E}}, bcnt);
    run("v10000_lz", 10000, 1'b1, {4{7'h7E}}, bcnt);
    run("v16383_lz", 16383, 1'b1, {4{7'h7E}}, bcnt);
    run("v9999", 9999, 1'b0, {4{7'h04}}, bcnt);

    // Load while busy is ignored
    pulse_load(1234, 1'b0);
    repeat (3) @(negedge clk);
    load  = 1'b1;
    value = 14'd5678;
    @(negedge clk);
    load = 1'b0;
    wait_done(bcnt, got);
    chk("busy_load_done", 30'(got), 30'd1);
    chk("busy_load_ignored", 30'({SSD3, SSD2, SSD1, SSD0}), 30'({7'h4F, 7'h12, 7'h06, 7'h4C}));

    // Load on the done cycle is accepted
    run("v5678_on_done", 5678, 1'b0, {7'h24, 7'h20, 7'h0F, 7'h00}, bcnt);
    chk("v5678_busy_len", 30'(bcnt), 30'd15);

    // Asynchronous reset mid-SHIFT discards the conversion
    pulse_load(1234, 1'b0);
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("mid_reset", {busy, done, SSD3, SSD2, SSD1, SSD0}, {2'b00, {4{7'h7F}}});
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_reset", 30'(nd), 30'd0);
    chk("dark_after_reset", 30'({SSD3, SSD2, SSD1, SSD0}), 30'({4{7'h7F}}));

    // Conversion works again after reset
    run("v42_lz", 42, 1'b1, {7'h7F, 7'h7F, 7'h4C, 7'h12}, bcnt);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
